// File: rtl/instr_queue.sv
// instr_queue: DEPTH-entry circular FIFO of {instr, pc} pairs between fetch
// and decode. First-word fall-through head, registered count/full/empty,
// flush discards all queued entries at the next edge.
// Optional feature: define IQ_BYPASS_EN to forward an incoming entry straight
// to the outputs while the queue is empty (zero-latency path).
module instr_queue #(
    parameter int INSTR_W = 32,
    parameter int PC_W    = 12,
    parameter int DEPTH   = 4,
    parameter int CNT_W   = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [PC_W-1:0]    in_pc,
    output logic               in_ready,
    output logic               out_valid,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_pc,
    input  logic               out_ready,
    input  logic               flush,
    output logic [CNT_W-1:0]   count,
    output logic               full,
    output logic               empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int ENT_W = INSTR_W + PC_W;

    logic [ENT_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             wr_en;
    logic             rd_en;
    logic             byp;

    // Status flags come only from registered state, so in_ready never
    // depends on out_ready (no decode-to-fetch combinational path).
    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_W'(DEPTH));
    assign count    = count_q;
    assign in_ready = rst & ~full;

`ifdef IQ_BYPASS_EN
    // Forward the fetch entry while nothing is stored; gated by rst so the
    // outputs stay quiet during reset.
    assign byp = rst & empty & in_valid & ~flush;
`else
    assign byp = 1'b0;
`endif

    // Head selection: stored entry first, then the bypassed input, else zero.
    always_comb begin
        out_valid = ~empty | byp;
        {out_instr, out_pc} = '0;
        if (!empty) begin
            {out_instr, out_pc} = mem_q[rd_ptr_q];
        end else if (byp) begin
            {out_instr, out_pc} = {in_instr, in_pc};
        end
    end

    // Next-state for pointers and occupancy; flush wins over push and pop.
    always_comb begin
        // A bypassed entry consumed in the same cycle is never stored.
        wr_en    = in_valid & in_ready & ~(byp & out_ready) & ~flush;
        rd_en    = ~empty & out_ready & ~flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (rd_en) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(wr_en) - CNT_W'(rd_en);
        end
    end

    // Control state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are never cleared, only pointers are.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= {in_instr, in_pc};
        end
    end

endmodule

// File: tb/tb_instr_queue.sv
// Self-checking bench for instr_queue: vector table, hand-written corner
// sequences (wrap, bypass) and randomized traffic against a queue model.
module tb_instr_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_instr = '0;
    logic [11:0] in_pc = '0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [11:0] out_pc;
    logic        out_ready = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  count;
    logic        full;
    logic        empty;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    instr_queue #(.INSTR_W(32), .PC_W(12), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc), .in_ready(in_ready),
        .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc), .out_ready(out_ready),
        .flush(flush), .count(count), .full(full), .empty(empty)
    );

    typedef struct {
        logic        rst;
        logic        iv;
        logic [11:0] pc;
        logic        ordy;
        logic        fl;
        int          cnt;
        logic        rdy;
        logic        ov;
        logic [11:0] opc;
        logic        chk;
    } vec_t;

    vec_t tbl [23];
    logic [43:0] mq [$];

    function automatic vec_t mk(logic r, logic iv, logic [11:0] pc, logic ordy, logic fl,
                                int cnt, logic rdy, logic ov, logic [11:0] opc, logic chk);
        vec_t v;
        v.rst = r; v.iv = iv; v.pc = pc; v.ordy = ordy; v.fl = fl;
        v.cnt = cnt; v.rdy = rdy; v.ov = ov; v.opc = opc; v.chk = chk;
        return v;
    endfunction

    function automatic logic [31:0] instr_of(logic [11:0] pc);
        return 32'h13 + {18'd0, pc, 2'b00};
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic iv, input logic [31:0] ins,
                         input logic [11:0] pc, input logic ordy, input logic fl);
        @(negedge clk);
        rst = r; in_valid = iv; in_instr = ins; in_pc = pc; out_ready = ordy; flush = fl;
        #1;
    endtask

    initial begin
        // Rows: rst, in_valid, pc, out_ready, flush | count, in_ready, out_valid, out_pc, check head
        tbl[0]  = mk(0, 1, 12'h000, 0, 0, 0, 0, 0, 12'h000, 1);
        tbl[1]  = mk(0, 1, 12'h000, 0, 0, 0, 0, 0, 12'h000, 1);
        tbl[2]  = mk(1, 1, 12'h000, 0, 0, 0, 1, 0, 12'h000, 0);
        tbl[3]  = mk(1, 1, 12'h004, 0, 0, 1, 1, 1, 12'h000, 1);
        tbl[4]  = mk(1, 1, 12'h008, 0, 0, 2, 1, 1, 12'h000, 1);
        tbl[5]  = mk(1, 1, 12'h00C, 0, 0, 3, 1, 1, 12'h000, 1);
        tbl[6]  = mk(1, 1, 12'h010, 0, 0, 4, 0, 1, 12'h000, 1);
        tbl[7]  = mk(1, 0, 12'h000, 1, 0, 4, 0, 1, 12'h000, 1);
        tbl[8]  = mk(1, 0, 12'h000, 1, 0, 3, 1, 1, 12'h004, 1);
        tbl[9]  = mk(1, 0, 12'h000, 1, 0, 2, 1, 1, 12'h008, 1);
        tbl[10] = mk(1, 0, 12'h000, 1, 0, 1, 1, 1, 12'h00C, 1);
        tbl[11] = mk(1, 0, 12'h000, 0, 0, 0, 1, 0, 12'h000, 1);
        tbl[12] = mk(1, 1, 12'h020, 0, 0, 0, 1, 0, 12'h000, 0);
        tbl[13] = mk(1, 1, 12'h024, 0, 0, 1, 1, 1, 12'h020, 1);
        tbl[14] = mk(1, 1, 12'h028, 0, 0, 2, 1, 1, 12'h020, 1);
        tbl[15] = mk(1, 1, 12'h02C, 0, 0, 3, 1, 1, 12'h020, 1);
        tbl[16] = mk(1, 1, 12'h030, 1, 0, 4, 0, 1, 12'h020, 1);
        tbl[17] = mk(1, 0, 12'h000, 0, 0, 3, 1, 1, 12'h024, 1);
        tbl[18] = mk(1, 1, 12'h034, 1, 1, 3, 1, 1, 12'h024, 1);
        tbl[19] = mk(1, 1, 12'h100, 0, 0, 0, 1, 0, 12'h000, 0);
        tbl[20] = mk(1, 0, 12'h000, 0, 0, 1, 1, 1, 12'h100, 1);
        tbl[21] = mk(1, 0, 12'h000, 1, 0, 1, 1, 1, 12'h100, 1);
        tbl[22] = mk(1, 0, 12'h000, 0, 0, 0, 1, 0, 12'h000, 1);

        // One reset edge so state is defined before the first table row.
        @(posedge clk);

        for (int i = 0; i < 23; i++) begin
            drive(tbl[i].rst, tbl[i].iv, instr_of(tbl[i].pc), tbl[i].pc, tbl[i].ordy, tbl[i].fl);
            check($sformatf("tbl%0d_count", i), 64'(count), 64'(tbl[i].cnt));
            check($sformatf("tbl%0d_in_ready", i), 64'(in_ready), 64'(tbl[i].rdy));
            check($sformatf("tbl%0d_full", i), 64'(full), 64'(tbl[i].cnt == DEPTH));
            check($sformatf("tbl%0d_empty", i), 64'(empty), 64'(tbl[i].cnt == 0));
            if (tbl[i].chk) begin
                check($sformatf("tbl%0d_out_valid", i), 64'(out_valid), 64'(tbl[i].ov));
                check($sformatf("tbl%0d_out_pc", i), 64'(out_pc), 64'(tbl[i].ov ? tbl[i].opc : 12'h0));
                check($sformatf("tbl%0d_out_instr", i), 64'(out_instr),
                      64'(tbl[i].ov ? instr_of(tbl[i].opc) : 32'h0));
            end
        end

        // Sustained push+pop across pointer wrap.
        for (int k = 0; k < 10; k++) begin
            logic [11:0] pc;
            pc = 12'h200 + 12'(4 * k);
            drive(1, 1, instr_of(pc), pc, 1, 0);
`ifdef IQ_BYPASS_EN
            check("wrap_out_valid", 64'(out_valid), 64'(1));
            check("wrap_out_pc", 64'(out_pc), 64'(pc));
            check("wrap_count", 64'(count), 64'(0));
`else
            if (k == 0) begin
                check("wrap_first_out_valid", 64'(out_valid), 64'(0));
                check("wrap_first_count", 64'(count), 64'(0));
            end else begin
                check("wrap_count", 64'(count), 64'(1));
                check("wrap_out_pc", 64'(out_pc), 64'(pc - 12'h4));
                check("wrap_out_instr", 64'(out_instr), 64'(instr_of(pc - 12'h4)));
            end
`endif
        end
        drive(1, 0, 32'h0, 12'h0, 1, 0);
`ifndef IQ_BYPASS_EN
        check("wrap_tail_pc", 64'(out_pc), 64'(12'h224));
`endif
        drive(1, 0, 32'h0, 12'h0, 0, 0);
        check("wrap_drained_empty", 64'(empty), 64'(1));
        check("wrap_drained_count", 64'(count), 64'(0));

        // Empty queue, entry offered with decode ready.
        drive(1, 1, 32'h00500093, 12'h300, 1, 0);
`ifdef IQ_BYPASS_EN
        check("byp_same_valid", 64'(out_valid), 64'(1));
        check("byp_same_instr", 64'(out_instr), 64'(32'h00500093));
        check("byp_same_pc", 64'(out_pc), 64'(12'h300));
`else
        check("byp_same_valid", 64'(out_valid), 64'(0));
`endif
        drive(1, 0, 32'h0, 12'h0, 0, 0);
`ifdef IQ_BYPASS_EN
        check("byp_next_count", 64'(count), 64'(0));
        check("byp_next_valid", 64'(out_valid), 64'(0));
`else
        check("byp_next_count", 64'(count), 64'(1));
        check("byp_next_valid", 64'(out_valid), 64'(1));
        check("byp_next_instr", 64'(out_instr), 64'(32'h00500093));
`endif
        drive(1, 0, 32'h0, 12'h0, 0, 1);
        mq.delete();

        // Randomized traffic against a plain queue model.
        for (int c = 0; c < 800; c++) begin
            logic r, iv, ordy, fl, byp, exp_rdy, exp_ov;
            logic [31:0] ins;
            logic [11:0] pc;
            logic [43:0] head;
            r    = ($urandom_range(59) != 0);
            fl   = ($urandom_range(24) == 0);
            iv   = ($urandom_range(9) < 7);
            ordy = ((c / 100) % 2 == 1) ? ($urandom_range(9) < 3) : ($urandom_range(9) < 8);
            ins  = $urandom;
            pc   = 12'($urandom);
            drive(r, iv, ins, pc, ordy, fl);

            exp_rdy = r && (mq.size() < DEPTH);
`ifdef IQ_BYPASS_EN
            byp = r && (mq.size() == 0) && iv && !fl;
`else
            byp = 1'b0;
`endif
            exp_ov = (mq.size() > 0) || byp;
            if (mq.size() > 0) head = mq[0];
            else if (byp)      head = {ins, pc};
            else               head = '0;

            check("rnd_in_ready", 64'(in_ready), 64'(exp_rdy));
            check("rnd_out_valid", 64'(out_valid), 64'(exp_ov));
            check("rnd_head", 64'({out_instr, out_pc}), 64'(head));
            check("rnd_count", 64'(count), 64'(mq.size()));
            check("rnd_full", 64'(full), 64'(mq.size() == DEPTH));
            check("rnd_empty", 64'(empty), 64'(mq.size() == 0));

            if (!r || fl) begin
                mq.delete();
            end else if (!(byp && ordy)) begin
                if (exp_ov && ordy) void'(mq.pop_front());
                if (iv && exp_rdy) mq.push_back({ins, pc});
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_queue.md
# instr_queue

Parametrised instruction queue between the fetch and decode stages. It replaces the single-entry, always-advancing fetch latch with a DEPTH-entry circular FIFO that carries {instr, pc} pairs. Valid/ready handshakes on both sides let decode stall without losing fetched instructions, and a flush port discards all queued entries on redirect.

## Interface
Parameters:
- INSTR_W, 32, instruction width in bits
- PC_W, 12, PC width in bits (matches fetch PC)
- DEPTH, 4, entry count; power of two, ≥ 2
- CNT_W, $clog2(DEPTH)+1, occupancy counter width (derived; do not override)

Ports:
- clk  in  1  sole clock; all state updates on rising edge
- rst  in  1  synchronous, active-low reset (one clock; reset is synchronous and active-low)
- in_valid  in  1  fetch presents an entry
- in_instr  in  INSTR_W  fetched instruction
- in_pc  in  PC_W  PC of in_instr
- in_ready  out  1  queue accepts an entry this cycle
- out_valid  out  1  head entry valid
- out_instr  out  INSTR_W  head instruction
- out_pc  out  PC_W  head PC
- out_ready  in  1  decode consumes head this cycle
- flush  in  1  discard all entries (branch redirect / exception)
- count  out  CNT_W  current occupancy, 0..DEPTH
- full  out  1  count == DEPTH
- empty  out  1  count == 0

## Operation
- Storage: DEPTH × (INSTR_W+PC_W) array; wr_ptr and rd_ptr of $clog2(DEPTH) bits wrap naturally; count tracked separately (no pointer-MSB trick).
- push = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready = rst & !full. It depends only on state, never on out_ready, so there is no combinational path from decode to fetch. A push into a full queue is never accepted, even when a pop occurs in the same cycle.
- out_valid = !empty. Head is read combinationally from mem[rd_ptr] (first-word fall-through). While empty, out_instr and out_pc are driven 0.
- Push only: write mem[wr_ptr], wr_ptr+1, count+1.
- Pop only: rd_ptr+1, count−1.
- Push and pop in the same cycle: both pointers advance and count is unchanged.
- Flush, which has priority over push and pop: wr_ptr=rd_ptr=0 and count=0 at the next edge. A push or pop in the flush cycle is discarded or ignored. The array contents are not cleared.
- Reset (rst=0 at the edge): pointers=0, count=0. The cycle after, outputs are out_valid=0, out_instr=0, out_pc=0, empty=1, full=0, count=0. in_ready=0 while rst is low.
- Reset mid-stream: all entries are lost, with the same result as flush.
- Pointer wrap at DEPTH−1→0 is transparent. Ordering is strictly FIFO.

## Timing
- Push-to-output latency is 1 cycle: an entry pushed at edge N is visible on out_* after edge N. With IQ_BYPASS_EN the latency is 0 when the queue is empty.
- Throughput is 1 push and 1 pop per cycle sustained at any occupancy 1..DEPTH−1.
- full, empty and count are registered-state derived and update the cycle after the causing edge.
- flush takes effect at the next edge. out_valid is 0 in the cycle after flush unless bypass applies.

## Configuration
- IQ_BYPASS_EN defined: when empty & in_valid & !flush, then out_valid=1 and out_instr/out_pc = in_instr/in_pc combinationally. If out_ready is also 1, the entry is consumed directly: no write, and count stays 0. Otherwise the entry is written normally. count and empty still reflect stored entries only.
- IQ_BYPASS_EN undefined: no input-to-output combinational path, and the minimum latency is 1 cycle.

## Test plan
- Reset: hold rst=0 for 2 cycles with in_valid=1 → count=0, out_valid=0, in_ready=0, out_instr=0. Release → in_ready=1.
- Fill/drain: push 0x00000013..0x00000043 with PCs 0x000,0x004,0x008,0x00C while out_ready=0 → full=1, in_ready=0, count=4. Then out_ready=1 → same order popped over 4 cycles, then empty=1.
- Wrap and simultaneous operations: 10 cycles with in_valid=1 and out_ready=1, PCs incrementing by 4 → count holds at 1 after the first cycle, out_pc lags in_pc by one cycle, no loss across pointer wrap.
- Full + pop: count=4, in_valid=1, out_ready=1 → push rejected, count=3 next cycle, head advances.
- Flush: count=3, assert flush with in_valid=1 and out_ready=1 → count=0, empty=1 next cycle. A following push of PC 0x100 appears as the head with no stale data.
- Bypass (IQ_BYPASS_EN): queue empty, in_valid=1, out_ready=1, instr 0x00500093 → out_instr=0x00500093 in the same cycle, count stays 0. Without the macro, out_valid=0 in that cycle and the entry appears 1 cycle later.
